tao_bus_arbiter: RTL and testbench
==================================

# tao_bus_arbiter

Round-robin arbiter and sequencer that shares one ThreeAndOut bus master port between `N_REQ` producer threads. Each requester presents a 24-bit packet with a level request. The arbiter picks a winner, latches its packet and drives the three-beat ThreeAndOut protocol: `StartNow` with the high byte, then the middle byte, then the low byte. It sits between the producer-side testbench/talker threads and the `ThreeAndOut.master` wires, and replaces the per-talker FSM when more than one producer shares the bus.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `clk`  input  1: bus clock; all state changes on its rising edge.
- `reset_L`  input  1: asynchronous, active-low reset.
- `req`  input  N_REQ: per-requester level request.
- `pkt`  input  24*N_REQ: packet for requester i in `pkt[24*i +: 24]`; bits [23:16] are sent first.
- `gnt`  output  N_REQ: one-cycle pulse showing that requester i's packet was latched.
- `done`  output  N_REQ: one-cycle pulse during the low-byte beat of requester i's packet.
- `StartNow`  output  1: ThreeAndOut start strobe.
- `data`  output  8: ThreeAndOut data byte.
- `busy`  output  1: high in any beat or gap state.

## Operation
- States: IDLE, HI, MID, LO, and GAP (GAP exists only when the macro is defined).
- Outputs are registered or decoded purely from state and the latched packet. There is no combinational path from `req` to the bus.
- **Arbitration** is performed at the clock edge that leaves IDLE, and at the edge that leaves LO.
  - The search starts at requester (`last`+1) mod `N_REQ` and takes the first asserted `req`.
  - On a win: latch `pkt[winner]`, set `last` to the winner, set `gnt[winner]`=1 for the next cycle, and go to HI.
  - With no request, go to (or stay in) IDLE.
- **IDLE**: `StartNow`=0, `data`=8'h00, `busy`=0.
- **HI**: `StartNow`=1, `data`=pkt[23:16]. Go to MID.
- **MID**: `StartNow`=0, `data`=pkt[15:8]. Go to LO.
- **LO**: `StartNow`=0, `data`=pkt[7:0], `done[winner]`=1.
  - Without the macro: arbitrate. A winner goes to HI (back-to-back packets); otherwise go to IDLE.
  - With the macro: go to GAP.
- **GAP**: `StartNow`=0, `data`=8'h00. Go to IDLE.
- **Requester rules**:
  - `req` and `pkt[i]` must stay stable from assertion until `gnt[i]`.
  - `req[i]` must be dropped in the `gnt[i]` cycle or the cycle after.
  - A `req[i]` still high at the next arbitration edge is a new request.
- A requester cannot cancel. Dropping `req` before `gnt` is legal only if no arbitration edge occurred while it was high.
- At most one `gnt` bit and at most one `done` bit are high in any cycle.
- **Reset state**: state=IDLE and `last`=N_REQ-1, so requester 0 has priority at the first arbitration. All outputs are 0.

## Timing
- Request latency: with `req[i]` high in IDLE at edge E, the HI beat and `gnt[i]` occur in cycle E+1, MID in E+2, and LO plus `done[i]` in E+3.
- Each packet occupies exactly 3 bus cycles.
- Without the macro, sustained requests yield one packet every 3 cycles; `StartNow` can recur 3 cycles apart.
- With the macro, the minimum spacing is 5 cycles: LO, then GAP, then IDLE arbitrates, then HI.
- Simultaneous requests: exactly one wins, in round-robin order. Losers keep `req` high and are served in rotation, with no starvation.
- Reset asserted mid-packet: all outputs are 0 immediately (asynchronously). The packet is abandoned, with no `done` and no retry. After release the arbiter is in IDLE and `last`=N_REQ-1.
- A `req` rising in the same cycle as LO is considered at that edge.

## Configuration
- `TAO_ARB_GAP_EN`:
  - When defined, one idle GAP cycle is inserted after every packet, giving a guaranteed `StartNow`-low separation for slow listeners.
  - When undefined, packets run back-to-back with no idle cycles between granted requests.

## Test plan
- Single packet, `N_REQ`=4: `req[2]`=1 with `pkt[2]`=24'h012345 in IDLE.
  - Next cycles give HI/MID/LO with `data`=01, 23, 45 and `StartNow`=1 only on the 01 beat.
  - `gnt[2]` is high on the HI beat and `done[2]` on the LO beat.
- Simultaneous requests from reset: `req[0]` and `req[3]` raised together.
  - Requester 0 is served first (0xAAAAAA), then requester 3 (0xBBBBBB).
  - Without the macro the second `StartNow` comes exactly 3 cycles after the first.
- Fairness: all four `req` held high continuously for 12 packets, with `req` re-raised after each `gnt`.
  - Grant order is 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3.
  - `busy` never drops.
- Reset mid-packet: `reset_L`=0 during the MID beat of 24'hFEDCBA.
  - `StartNow`, `data`, `gnt`, `done` and `busy` go to 0 without waiting for an edge, and no `done` fires.
  - After release, `req[1]` wins before `req[2]`.
- With `TAO_ARB_GAP_EN`: two back-to-back requests produce exactly one GAP cycle with `data`=00 plus one IDLE cycle between the LO beat and the next HI beat, so `StartNow` edges are 5 cycles apart.

Source files
------------

// File: rtl/tao_bus_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | tao_bus_arbiter_if                                                         |
// | Requester-side and ThreeAndOut-side signals of the shared bus arbiter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface tao_bus_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]    req;
   logic [24*N_REQ-1:0] pkt;
   logic [N_REQ-1:0]    gnt;
   logic [N_REQ-1:0]    done;
   logic                StartNow;
   logic [7:0]          data;
   logic                busy;

   modport master (
      input  req, pkt,
      output gnt, done, StartNow, data, busy
   );

   modport slave (
      output req, pkt,
      input  gnt, done, StartNow, data, busy
   );
endinterface

`default_nettype wire

// File: rtl/tao_bus_arbiter.sv
// +----------------------------------------------------------------------------+
// | tao_bus_arbiter                                                            |
// | Round-robin arbiter driving the three-beat ThreeAndOut master protocol.    |
// | Option macro: TAO_ARB_GAP_EN inserts one idle GAP beat after each packet.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tao_bus_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic               clk,
   input  logic               reset_L,
   tao_bus_arbiter_if.master  bus
);

   localparam int c_IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [2:0] c_ST_IDLE = 3'd0;
   localparam logic [2:0] c_ST_HI   = 3'd1;
   localparam logic [2:0] c_ST_MID  = 3'd2;
   localparam logic [2:0] c_ST_LO   = 3'd3;
`ifdef TAO_ARB_GAP_EN
   localparam logic [2:0] c_ST_GAP  = 3'd4;
`endif

   logic [2:0]      r_state;
   logic [2:0]      w_state_nxt;
   logic [23:0]     r_pkt;
   logic [c_IW-1:0] r_win;
   logic [c_IW-1:0] r_last;
   logic [c_IW-1:0] w_winner;
   logic [c_IW-1:0] w_idx;
   logic            w_found;
   logic            w_load;
   logic [N_REQ-1:0] w_onehot;
   logic [23:0]     w_lane [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pkt_lane
         assign w_lane[gi] = bus.pkt[24*gi +: 24];
      end
   endgenerate

   // Walk from last+N_REQ down to last+1 so the nearest requester after last wins.
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_last;
      w_idx    = r_last;
      for (int k = N_REQ; k >= 1; k--) begin
         w_idx = c_IW'((int'(r_last) + k) % N_REQ);
         if (bus.req[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_state <= c_ST_IDLE;
         r_pkt   <= 24'h000000;
         r_win   <= '0;
         r_last  <= c_IW'(N_REQ - 1);
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_pkt  <= w_lane[w_winner];
            r_win  <= w_winner;
            r_last <= w_winner;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            if (w_found) begin
               w_state_nxt = c_ST_HI;
               w_load      = 1'b1;
            end
         end
         c_ST_HI:  w_state_nxt = c_ST_MID;
         c_ST_MID: w_state_nxt = c_ST_LO;
         c_ST_LO: begin
`ifdef TAO_ARB_GAP_EN
            w_state_nxt = c_ST_GAP;
`else
            if (w_found) begin
               w_state_nxt = c_ST_HI;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = c_ST_IDLE;
            end
`endif
         end
`ifdef TAO_ARB_GAP_EN
         c_ST_GAP: w_state_nxt = c_ST_IDLE;
`endif
         default:  w_state_nxt = c_ST_IDLE;
      endcase
   end

   // Bus outputs decode only state and latched packet, so reset clears them at once.
   always_comb begin
      w_onehot     = {{(N_REQ-1){1'b0}}, 1'b1} << r_win;
      bus.StartNow = 1'b0;
      bus.data     = 8'h00;
      bus.busy     = 1'b0;
      bus.gnt      = '0;
      bus.done     = '0;
      case (r_state)
         c_ST_HI: begin
            bus.StartNow = 1'b1;
            bus.data     = r_pkt[23:16];
            bus.busy     = 1'b1;
            bus.gnt      = w_onehot;
         end
         c_ST_MID: begin
            bus.data = r_pkt[15:8];
            bus.busy = 1'b1;
         end
         c_ST_LO: begin
            bus.data = r_pkt[7:0];
            bus.busy = 1'b1;
            bus.done = w_onehot;
         end
`ifdef TAO_ARB_GAP_EN
         c_ST_GAP: bus.busy = 1'b1;
`endif
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_tao_bus_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_tao_bus_arbiter                                                         |
// | Directed self-checking bench for tao_bus_arbiter with N_REQ = 4.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tao_bus_arbiter;

   localparam int N_REQ = 4;
`ifdef TAO_ARB_GAP_EN
   localparam int c_SPACING = 5;
`else
   localparam int c_SPACING = 3;
`endif

   logic clk;
   logic reset_L;
   int   n_tests;
   int   n_fail;

   tao_bus_arbiter_if #(.N_REQ(N_REQ)) bus ();

   tao_bus_arbiter #(.N_REQ(N_REQ)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bus(input string tag, input logic st, input logic [7:0] dat,
                          input logic [3:0] g, input logic [3:0] d, input logic b);
      chk({tag, "_start"}, 32'(bus.StartNow), 32'(st));
      chk({tag, "_data"},  32'(bus.data),     32'(dat));
      chk({tag, "_gnt"},   32'(bus.gnt),      32'(g));
      chk({tag, "_done"},  32'(bus.done),     32'(d));
      chk({tag, "_busy"},  32'(bus.busy),     32'(b));
   endtask

   initial begin
      int          sp;
      int          k;
      logic        seen;
      logic [3:0]  rr;
      logic [23:0] p;

      n_tests  = 0;
      n_fail   = 0;
      reset_L  = 1'b0;
      bus.req  = '0;
      bus.pkt  = '0;

      repeat (2) step();
      chk_bus("reset", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
      reset_L = 1'b1;
      step();
      chk_bus("idle", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);

      // single packet from requester 2
      bus.pkt[48 +: 24] = 24'h012345;
      bus.req = 4'b0100;
      step();
      chk_bus("t1_hi", 1'b1, 8'h01, 4'b0100, 4'h0, 1'b1);
      bus.req = 4'b0000;
      step();
      chk_bus("t1_mid", 1'b0, 8'h23, 4'h0, 4'h0, 1'b1);
      step();
      chk_bus("t1_lo", 1'b0, 8'h45, 4'h0, 4'b0100, 1'b1);
      step();
`ifdef TAO_ARB_GAP_EN
      chk_bus("t1_gap", 1'b0, 8'h00, 4'h0, 4'h0, 1'b1);
      step();
`endif
      chk_bus("t1_idle", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);

      // simultaneous requests 0 and 3 straight out of reset
      reset_L = 1'b0;
      step();
      reset_L = 1'b1;
      bus.pkt[0 +: 24]  = 24'hAAAAAA;
      bus.pkt[72 +: 24] = 24'hBBBBBB;
      bus.req = 4'b1001;
      step();
      chk_bus("t2_hi0", 1'b1, 8'hAA, 4'b0001, 4'h0, 1'b1);
      bus.req = 4'b1000;
      sp = -1;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (bus.StartNow === 1'b1 && sp < 0) begin
            sp = c;
            chk("t2_gnt3",  32'(bus.gnt),  32'h8);
            chk("t2_data3", 32'(bus.data), 32'hBB);
            bus.req = 4'b0000;
         end
      end
      chk("t2_spacing", 32'(sp), 32'(c_SPACING));
      chk_bus("t2_end", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);

      // fairness: all four requesters continuously re-requesting
      for (int i = 0; i < N_REQ; i++) begin
         p = {4'(i), 4'h1, 4'(i), 4'h2, 4'(i), 4'h3};
         bus.pkt[24*i +: 24] = p;
      end
      bus.req = 4'b1111;
      rr = 4'b0000;
      k = 0;
      for (int c = 0; c < 80 && k < 12; c++) begin
         step();
         bus.req = bus.req | rr;
         rr = 4'b0000;
`ifndef TAO_ARB_GAP_EN
         chk("t3_busy", 32'(bus.busy), 32'h1);
`endif
         if (bus.gnt !== 4'b0000) begin
            chk("t3_gnt",  32'(bus.gnt),  32'(4'b0001 << (k % 4)));
            chk("t3_data", 32'(bus.data), 32'({4'(k % 4), 4'h1}));
            rr = bus.gnt;
            bus.req = bus.req & ~bus.gnt;
            k++;
         end
      end
      chk("t3_count", 32'(k), 32'd12);
      bus.req = 4'b0000;
      for (int c = 0; c < 10 && bus.busy === 1'b1; c++) step();
      chk("t3_drain", 32'(bus.busy), 32'h0);

      // reset during the MID beat of requester 1's packet
      bus.pkt[24 +: 24] = 24'hFEDCBA;
      bus.req = 4'b0010;
      step();
      chk_bus("t4_hi", 1'b1, 8'hFE, 4'b0010, 4'h0, 1'b1);
      bus.req = 4'b0000;
      step();
      chk_bus("t4_mid", 1'b0, 8'hDC, 4'h0, 4'h0, 1'b1);
      #2;
      reset_L = 1'b0;
      #1;
      chk_bus("t4_async", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
      bus.pkt[24 +: 24] = 24'h111111;
      bus.pkt[48 +: 24] = 24'h222222;
      bus.req = 4'b0110;
      step();
      chk_bus("t4_held", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
      step();
      reset_L = 1'b1;
      step();
      chk_bus("t4_win1", 1'b1, 8'h11, 4'b0010, 4'h0, 1'b1);
      bus.req = 4'b0100;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (bus.gnt !== 4'b0000 && !seen) begin
            chk("t4_gnt2",  32'(bus.gnt),  32'h4);
            chk("t4_data2", 32'(bus.data), 32'h22);
            bus.req = 4'b0000;
            seen = 1'b1;
         end
      end
      chk("t4_seen2", 32'(seen), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
